// File: rtl/rst_seq.sv
// Reset sequencer: releases ROM, then memories A/B/C, then controller, after a synchronised power-on release.
// Latency: HOLD_CYCLES after the synchronised release to ROM, then GAP/mem_ready/GAP steps; all outputs registered.
// Backpressure: none; mem_ready stalls the controller release up to TIMEOUT_CYCLES, then the sequence continues flagged.
module rst_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int HOLD_CYCLES    = 16,
    parameter int GAP_CYCLES     = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int CNT_W          = 11
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sw_rst_req,
    input  logic mem_ready,
    output logic rom_rst,
    output logic mem_a_rst,
    output logic mem_b_rst,
    output logic mem_c_rst,
    output logic ctrl_rst,
    output logic seq_done,
    output logic timeout_err
);

    typedef enum logic [2:0] {
        HOLD     = 3'd0,
        GAP1     = 3'd1,
        WAIT_MEM = 3'd2,
        GAP2     = 3'd3,
        RUN      = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rel_q;
    state_t                 state_q;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic                   cnt_inc;
    logic                   tmo_set;

    // Assertion clears the chain asynchronously; release ripples through it.
    // rel_q marks the first edge that sees the synchronised release (t0),
    // so HOLD timing matches a software re-entry, where t0 is the entry edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            rel_q  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b1};
            rel_q  <= sync_q[SYNC_STAGES-1];
        end
    end

    always_comb begin
        state_nxt = state_q;
        cnt_inc   = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            HOLD: begin
                if (rel_q) begin
                    if (cnt_q == HOLD_LAST) state_nxt = GAP1;
                    else                    cnt_inc   = 1'b1;
                end
            end
            GAP1: begin
                if (cnt_q == GAP_LAST) state_nxt = WAIT_MEM;
                else                   cnt_inc   = 1'b1;
            end
            WAIT_MEM: begin
                // mem_ready takes priority over an expiring timeout
                if (mem_ready) begin
                    state_nxt = GAP2;
                end else if (cnt_q == TMO_LAST) begin
                    state_nxt = GAP2;
                    tmo_set   = 1'b1;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            GAP2: begin
                if (cnt_q == GAP_LAST) state_nxt = RUN;
                else                   cnt_inc   = 1'b1;
            end
            RUN: begin
                if (sw_rst_req) state_nxt = HOLD;
            end
            default: state_nxt = HOLD;
        endcase
    end

    always_comb begin
        cnt_nxt = cnt_q;
        if (state_nxt != state_q) begin
            cnt_nxt = '0;
        end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
            cnt_nxt = cnt_q + CNT_W'(1);
        end
    end

    // Outputs decode the next state so they change on the transition edge
    // and the release ordering follows directly from the state order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= HOLD;
            cnt_q       <= '0;
            rom_rst     <= 1'b1;
            mem_a_rst   <= 1'b1;
            mem_b_rst   <= 1'b1;
            mem_c_rst   <= 1'b1;
            ctrl_rst    <= 1'b1;
            seq_done    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_q     <= state_nxt;
            cnt_q       <= cnt_nxt;
            rom_rst     <= (state_nxt == HOLD);
            mem_a_rst   <= (state_nxt == HOLD) || (state_nxt == GAP1);
            mem_b_rst   <= (state_nxt == HOLD) || (state_nxt == GAP1);
            mem_c_rst   <= (state_nxt == HOLD) || (state_nxt == GAP1);
            ctrl_rst    <= (state_nxt != RUN);
            seq_done    <= (state_nxt == RUN);
            timeout_err <= timeout_err | tmo_set;
        end
    end

endmodule
